// File: rtl/dffre_bist_pkg.sv
// Shared types and constants for the reset/enable flop BIST checker.
// Imported by the LFSR sub-module and the checker top.
package dffre_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_CHECK,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int NUM_DIRECTED = 6;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int step_w(input int num_random);
    return $clog2(NUM_DIRECTED + num_random + 1);
  endfunction

endpackage

// File: rtl/dffre_bist_lfsr.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, shifting right.
// Load takes priority over advance; only bit 0 is consumed.
module dffre_bist_lfsr
  import dffre_bist_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_Load,
  input  logic i_Adv,
  output logic o_Bit
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (i_Load) begin
      lfsr_d = SEED;
    end else if (i_Adv) begin
      lfsr_d = {1'b0, lfsr_q[15:1]}
             ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign o_Bit = lfsr_q[0];

endmodule

// File: rtl/dffre_bist_checker.sv
// On-board stimulus/compare engine for a golden vs netlist DFF pair.
// DFFRE_BIST_FIRST_FAIL_EN adds first-fail index and error injection.
module dffre_bist_checker
  import dffre_bist_pkg::*;
#(
  parameter int          NUM_RANDOM   = 1000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          DRAIN_CYCLES = 5,
  parameter int          CNT_W        = 16,
  localparam int         STEP_W       = step_w(NUM_RANDOM)
) (
  input  logic             clk,
  input  logic             i_Reset_n,
  input  logic             i_Start,
  input  logic             i_Q_golden,
  input  logic             i_Q_netlist,
  output logic             o_Reset,
  output logic             o_Enable,
  output logic             o_D,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_Pass,
  output logic [CNT_W-1:0] o_Mismatch_Cnt
`ifdef DFFRE_BIST_FIRST_FAIL_EN
  ,
  output logic [STEP_W-1:0] o_First_Fail_Idx,
  input  logic              i_Force_Err
`endif
);

  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [STEP_W-1:0] LAST_STEP =
    STEP_W'(NUM_DIRECTED + NUM_RANDOM - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [DRN_W-1:0]  drn_q, drn_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rst_q, rst_d;
  logic              en_q, en_d;
  logic              din_q, din_d;
  logic              pass_q, pass_d;
  logic              enter, lfsr_load, lfsr_adv, lfsr_bit;
  logic              q_net, err;
`ifdef DFFRE_BIST_FIRST_FAIL_EN
  logic [STEP_W-1:0] ff_q, ff_d;
  assign q_net = i_Q_netlist ^ i_Force_Err;
`else
  assign q_net = i_Q_netlist;
`endif

  dffre_bist_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (i_Reset_n),
    .i_Load (lfsr_load),
    .i_Adv  (lfsr_adv),
    .o_Bit  (lfsr_bit)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    drn_d     = drn_q;
    cnt_d     = cnt_q;
    rst_d     = rst_q;
    en_d      = en_q;
    din_d     = din_q;
    pass_d    = pass_q;
    enter     = 1'b0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    err       = 1'b0;
`ifdef DFFRE_BIST_FIRST_FAIL_EN
    ff_d      = ff_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_Start) begin
          state_d   = ST_APPLY;
          step_d    = '0;
          enter     = 1'b1;
          cnt_d     = '0;
          pass_d    = 1'b0;
          lfsr_load = 1'b1;
`ifdef DFFRE_BIST_FIRST_FAIL_EN
          ff_d      = '1;
`endif
        end
      end
      ST_APPLY: state_d = ST_CHECK;
      ST_CHECK: begin
        err = i_Q_golden ^ q_net;
        if (err && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
`ifdef DFFRE_BIST_FIRST_FAIL_EN
        if (err && ff_q == '1) ff_d = step_q;
`endif
        if (step_q != LAST_STEP) begin
          state_d = ST_APPLY;
          step_d  = step_q + STEP_W'(1);
          enter   = 1'b1;
        end else begin
          state_d = ST_DRAIN;
          drn_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (drn_q == DRN_LAST) begin
          state_d = ST_DONE;
          pass_d  = (cnt_q == '0);
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Stimulus for the step being entered; unlisted signals hold.
    if (enter) begin
      unique case (step_d)
        STEP_W'(0): din_d = 1'b1;
        STEP_W'(1): rst_d = 1'b1;
        STEP_W'(2): en_d  = 1'b0;
        STEP_W'(3): en_d  = 1'b1;
        STEP_W'(4): din_d = 1'b0;
        STEP_W'(5): din_d = 1'b1;
        default: begin
          din_d    = lfsr_bit;
          lfsr_adv = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      drn_q   <= '0;
      cnt_q   <= '0;
      rst_q   <= 1'b0;
      en_q    <= 1'b0;
      din_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      drn_q   <= drn_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      en_q    <= en_d;
      din_q   <= din_d;
      pass_q  <= pass_d;
    end
  end

`ifdef DFFRE_BIST_FIRST_FAIL_EN
  always_ff @(posedge clk or negedge i_Reset_n) begin
    if (!i_Reset_n) ff_q <= '1;
    else            ff_q <= ff_d;
  end
  assign o_First_Fail_Idx = ff_q;
`endif

  assign o_Reset        = rst_q;
  assign o_Enable       = en_q;
  assign o_D            = din_q;
  assign o_Busy         = (state_q == ST_APPLY) ||
                          (state_q == ST_CHECK) ||
                          (state_q == ST_DRAIN);
  assign o_Done         = (state_q == ST_DONE);
  assign o_Pass         = pass_q;
  assign o_Mismatch_Cnt = cnt_q;

endmodule

// File: tb/tb_dffre_bist_checker.sv
// Directed bench for dffre_bist_checker with behavioural DUT flops.
// Honours DFFRE_BIST_FIRST_FAIL_EN when the RTL is built with it.
module tb_dffre_bist_checker;

  localparam int N   = 1006;
  localparam int N2  = 26;
  localparam int RUN = 2 * N + 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic net_mode = 1'b0;
  logic gq = 1'b0;
  logic gq2 = 1'b0;
  logic q_net;

  logic        o_rst, o_en, o_d, o_busy, o_done, o_pass;
  logic [15:0] o_cnt;
  logic        o_rst2, o_en2, o_d2, o_busy2, o_done2, o_pass2;
  logic [3:0]  o_cnt2;
`ifdef DFFRE_BIST_FIRST_FAIL_EN
  logic        force_err = 1'b0;
  logic [9:0]  ffi;
  logic [4:0]  ffi2;
`endif

  int vectors = 0;
  int errors = 0;

  logic er [N];
  logic ee [N];
  logic ed [N];
  int   zpre [N + 1];

  always #5 clk = ~clk;

  assign q_net = net_mode ? 1'b1 : gq;

  dffre_bist_checker u_dut (
    .clk            (clk),
    .i_Reset_n      (rst_n),
    .i_Start        (start),
    .i_Q_golden     (gq),
    .i_Q_netlist    (q_net),
    .o_Reset        (o_rst),
    .o_Enable       (o_en),
    .o_D            (o_d),
    .o_Busy         (o_busy),
    .o_Done         (o_done),
    .o_Pass         (o_pass),
    .o_Mismatch_Cnt (o_cnt)
`ifdef DFFRE_BIST_FIRST_FAIL_EN
    ,
    .o_First_Fail_Idx (ffi),
    .i_Force_Err      (force_err)
`endif
  );

  dffre_bist_checker #(.NUM_RANDOM(20), .CNT_W(4)) u_sat (
    .clk            (clk),
    .i_Reset_n      (rst_n),
    .i_Start        (start2),
    .i_Q_golden     (gq2),
    .i_Q_netlist    (~gq2),
    .o_Reset        (o_rst2),
    .o_Enable       (o_en2),
    .o_D            (o_d2),
    .o_Busy         (o_busy2),
    .o_Done         (o_done2),
    .o_Pass         (o_pass2),
    .o_Mismatch_Cnt (o_cnt2)
`ifdef DFFRE_BIST_FIRST_FAIL_EN
    ,
    .o_First_Fail_Idx (ffi2),
    .i_Force_Err      (1'b0)
`endif
  );

  // Behavioural DUT flops: sync active-low reset, enable.
  always @(posedge clk) begin
    gq  <= !o_rst  ? 1'b0 : (o_en  ? o_d  : gq);
    gq2 <= !o_rst2 ? 1'b0 : (o_en2 ? o_d2 : gq2);
  end

  task automatic build_model();
    logic r, e, d, q;
    logic [15:0] l;
    int z;
    r = 0; e = 0; d = 0; q = 0; z = 0;
    l = 16'hACE1;
    for (int s = 0; s < N; s++) begin
      zpre[s] = z;
      case (s)
        0: d = 1'b1;
        1: r = 1'b1;
        2: e = 1'b0;
        3: e = 1'b1;
        4: d = 1'b0;
        5: d = 1'b1;
        default: begin
          d = l[0];
          l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0);
        end
      endcase
      er[s] = r; ee[s] = e; ed[s] = d;
      q = !r ? 1'b0 : (e ? d : q);
      if (!q) z++;
    end
    zpre[N] = z;
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      #1;
      if (o_done) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk) rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_rst, o_en, o_d} !== 3'b000) begin
      errors++;
      $display("FAIL reset_stim: got %b want 000", {o_rst, o_en, o_d});
    end
    vectors++;
    if ({o_busy, o_done, o_pass} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000",
               {o_busy, o_done, o_pass});
    end
    vectors++;
    if (o_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d want 0", o_cnt);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int cyc;
    do_reset();
    net_mode = 1'b0;
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if ({o_rst, o_en, o_d, o_busy} !== {er[k], ee[k], ed[k], 1'b1}) begin
        errors++;
        $display("FAIL stim_step%0d: got %b want %b", k,
                 {o_rst, o_en, o_d, o_busy},
                 {er[k], ee[k], ed[k], 1'b1});
      end
      repeat (2) @(posedge clk);
      #1;
    end
    wait_done(RUN, cyc);
    vectors++;
    if (cyc != RUN - 32) begin
      errors++;
      $display("FAIL run_len: got %0d want %0d", cyc + 32, RUN);
    end
    vectors++;
    if ({o_pass, o_busy} !== 2'b10 || o_cnt !== 16'd0) begin
      errors++;
      $display("FAIL tied_pass: got pass=%b busy=%b cnt=%0d want 1 0 0",
               o_pass, o_busy, o_cnt);
    end
  endtask

  task automatic test_mismatch_count();
    int cyc;
    do_reset();
    net_mode = 1'b1;
    pulse_start();
    wait_done(RUN + 10, cyc);
    vectors++;
    if (cyc != RUN) begin
      errors++;
      $display("FAIL mm_run_len: got %0d want %0d", cyc, RUN);
    end
    vectors++;
    if (o_cnt !== 16'(zpre[N])) begin
      errors++;
      $display("FAIL mm_cnt: got %0d want %0d", o_cnt, zpre[N]);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({o_done, o_pass} !== 2'b10) begin
      errors++;
      $display("FAIL mm_flags: got done,pass=%b want 10", {o_done, o_pass});
    end
    net_mode = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_reset();
    net_mode = 1'b0;
    pulse_start();
    cyc = -1;
    for (int n = 1; n <= RUN + 10; n++) begin
      @(posedge clk);
      #1;
      start = (n == 100);
      if (o_done) begin
        cyc = n;
        break;
      end
    end
    start = 1'b0;
    vectors++;
    if (cyc != RUN) begin
      errors++;
      $display("FAIL restart_ignored: got %0d want %0d", cyc, RUN);
    end
    vectors++;
    if (o_pass !== 1'b1) begin
      errors++;
      $display("FAIL restart_pass: got %b want 1", o_pass);
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    do_reset();
    net_mode = 1'b1;
    pulse_start();
    repeat (600) @(posedge clk);
    #1;
    vectors++;
    if (o_cnt !== 16'(zpre[300]) || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_cnt: got %0d busy=%b want %0d busy=1",
               o_cnt, o_busy, zpre[300]);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_rst, o_en, o_d, o_busy, o_done, o_pass} !== 6'b0 ||
        o_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: got %b cnt=%0d want 000000 cnt=0",
               {o_rst, o_en, o_d, o_busy, o_done, o_pass}, o_cnt);
    end
    @(negedge clk) rst_n = 1'b1;
    net_mode = 1'b0;
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (o_d !== ed[k]) begin
        errors++;
        $display("FAIL restart_d%0d: got %b want %b", k, o_d, ed[k]);
      end
      repeat (2) @(posedge clk);
      #1;
    end
    wait_done(RUN, cyc);
    vectors++;
    if (cyc != RUN - 20 || o_pass !== 1'b1) begin
      errors++;
      $display("FAIL restart_run: got %0d pass=%b want %0d pass=1",
               cyc + 20, o_pass, RUN);
    end
  endtask

  task automatic test_saturate();
    int cyc;
    do_reset();
    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    cyc = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (o_done2) begin
        cyc = n;
        break;
      end
    end
    vectors++;
    if (cyc != 2 * N2 + 5) begin
      errors++;
      $display("FAIL sat_run_len: got %0d want %0d", cyc, 2 * N2 + 5);
    end
    vectors++;
    if (o_cnt2 !== 4'd15 || o_pass2 !== 1'b0) begin
      errors++;
      $display("FAIL sat_cnt: got %0d pass=%b want 15 pass=0",
               o_cnt2, o_pass2);
    end
  endtask

`ifdef DFFRE_BIST_FIRST_FAIL_EN
  task automatic test_first_fail();
    int cyc;
    do_reset();
    net_mode = 1'b0;
    pulse_start();
    vectors++;
    if (ffi !== 10'h3FF) begin
      errors++;
      $display("FAIL ff_clear: got %0d want 1023", ffi);
    end
    repeat (15) @(posedge clk);
    #1 force_err = 1'b1;
    @(posedge clk);
    #1 force_err = 1'b0;
    wait_done(RUN, cyc);
    vectors++;
    if (ffi !== 10'd7 || o_cnt !== 16'd1 || o_pass !== 1'b0) begin
      errors++;
      $display("FAIL ff_idx: got idx=%0d cnt=%0d pass=%b want 7 1 0",
               ffi, o_cnt, o_pass);
    end
  endtask
`endif

  initial begin
    build_model();
    test_reset();
    test_directed();
    test_mismatch_count();
    test_back_to_back();
    test_reset_midrun();
    test_saturate();
`ifdef DFFRE_BIST_FIRST_FAIL_EN
    test_first_fail();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
